// File: rtl/load_align_unit_pkg.sv
// Shared load/store type codes and helpers for the MEM-stage access units.
// Store codes feed byte-enable generation; load codes feed load_align_unit.
package load_align_unit_pkg;

    typedef enum logic [1:0] {
        StoreByte = 2'b00,
        StoreHalf = 2'b01,
        StoreWord = 2'b10
    } store_type_e;

    typedef enum logic [2:0] {
        LoadWord  = 3'b000,
        LoadHalf  = 3'b001,
        LoadHalfU = 3'b010,
        LoadByte  = 3'b011,
        LoadByteU = 3'b100
    } load_type_e;

    localparam int LOAD_TYPE_W = 3;

    function automatic logic is_load_type(input logic [LOAD_TYPE_W-1:0] t);
        return (t <= LoadByteU);
    endfunction

    // Words need a 4-byte boundary, halfwords a 2-byte boundary, bytes never trap.
    function automatic logic is_misaligned(input logic [LOAD_TYPE_W-1:0] t,
                                           input logic [1:0]             addr_lo);
        logic mis;
        mis = 1'b0;
        case (t)
            LoadWord:            mis = (addr_lo != 2'b00);
            LoadHalf, LoadHalfU: mis = addr_lo[0];
            default:             mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_align_unit_extract.sv
// Combinational lane select and sign/zero extension of a 32-bit read word.
// Half lanes use addr_lo[1] only; byte lanes use addr_lo[1:0].
module load_extract
    import load_align_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [2:0]  ld_type,
    input  logic [1:0]  addr_lo,
    output logic [31:0] data
);

    logic [15:0] half_sel;
    logic [7:0]  byte_sel;

    always_comb begin
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        byte_sel = rdata[7:0];
        case (addr_lo)
            2'b00:   byte_sel = rdata[7:0];
            2'b01:   byte_sel = rdata[15:8];
            2'b10:   byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
    end

    always_comb begin
        data = '0;
        case (ld_type)
            LoadWord:  data = rdata;
            LoadHalf:  data = {{16{half_sel[15]}}, half_sel};
            LoadHalfU: data = {16'h0000, half_sel};
            LoadByte:  data = {{24{byte_sel[7]}}, byte_sel};
            LoadByteU: data = {24'h000000, byte_sel};
            default:   data = '0;
        endcase
    end

endmodule

// File: rtl/load_align_unit.sv
// MEM-stage load reader: word-aligned req/ack read, lane extract, stall until done.
// Optional macro LOAD_MISALIGN_TRAP_EN: misaligned LW/LH/LHU trap via ld_misalign.
module load_align_unit
    import load_align_unit_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_valid,
    input  logic [2:0]        ld_type,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic              flush,
    output logic              stall,
    output logic              ld_done,
    output logic [DATA_W-1:0] ld_data,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
`ifdef LOAD_MISALIGN_TRAP_EN
    output logic              ld_misalign,
`endif
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        REQ   = 2'b01,
        DRAIN = 2'b10,
        DONE  = 2'b11
    } state_e;

    state_e            state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [2:0]        type_q, type_d;
    logic [1:0]        addr_lo_q, addr_lo_d;
    logic [DATA_W-1:0] ld_data_q, ld_data_d;
    logic              ld_done_q, ld_done_d;
    logic              accept;
    logic [31:0]       extracted;
`ifdef LOAD_MISALIGN_TRAP_EN
    logic              misalign_q, misalign_d;
`endif

    load_extract u_extract (
        .rdata   (mem_rdata),
        .ld_type (type_q),
        .addr_lo (addr_lo_q),
        .data    (extracted)
    );

    assign accept = ld_valid & is_load_type(ld_type) & ~flush;

    always_comb begin
        state_d    = state_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        type_d     = type_q;
        addr_lo_d  = addr_lo_q;
        ld_data_d  = ld_data_q;
        ld_done_d  = 1'b0;
        stall      = 1'b0;
`ifdef LOAD_MISALIGN_TRAP_EN
        misalign_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                stall = accept;
                if (accept) begin
                    type_d    = ld_type;
                    addr_lo_d = ld_addr[1:0];
`ifdef LOAD_MISALIGN_TRAP_EN
                    // A trapped load skips the bus and reuses DONE for its single pulse.
                    if (is_misaligned(ld_type, ld_addr[1:0])) begin
                        misalign_d = 1'b1;
                        state_d    = DONE;
                    end else
`endif
                    begin
                        mem_req_d  = 1'b1;
                        mem_addr_d = {ld_addr[ADDR_W-1:2], 2'b00};
                        state_d    = REQ;
                    end
                end
            end
            REQ: begin
                stall = 1'b1;
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    if (flush) begin
                        state_d = IDLE;
                    end else begin
                        ld_data_d = extracted;
                        ld_done_d = 1'b1;
                        state_d   = DONE;
                    end
                end else if (flush) begin
                    state_d = DRAIN;
                end
            end
            // The bus cannot abort, so a flushed request waits here for its ack.
            DRAIN: begin
                stall = 1'b1;
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            type_q     <= '0;
            addr_lo_q  <= '0;
            ld_data_q  <= '0;
            ld_done_q  <= 1'b0;
`ifdef LOAD_MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            type_q     <= type_d;
            addr_lo_q  <= addr_lo_d;
            ld_data_q  <= ld_data_d;
            ld_done_q  <= ld_done_d;
`ifdef LOAD_MISALIGN_TRAP_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;
    assign ld_data  = ld_data_q;
    assign ld_done  = ld_done_q;
`ifdef LOAD_MISALIGN_TRAP_EN
    assign ld_misalign = misalign_q;
`endif

endmodule

// File: tb/tb_load_align_unit.sv
// Directed, table-driven bench for load_align_unit (both LOAD_MISALIGN_TRAP_EN builds).
module tb_load_align_unit;
    import load_align_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_valid;
    logic [2:0]  ld_type;
    logic [31:0] ld_addr;
    logic        flush;
    logic        stall;
    logic        ld_done;
    logic [31:0] ld_data;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
`ifdef LOAD_MISALIGN_TRAP_EN
    logic        ld_misalign;
`endif

    int tests_run    = 0;
    int tests_failed = 0;
    logic [31:0] last_data;

    typedef struct {
        logic [2:0]  ld_type;
        logic [31:0] addr;
        logic [31:0] rdata;
        int          waits;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[12];
    int   num_vecs;

    load_align_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .ld_valid    (ld_valid),
        .ld_type     (ld_type),
        .ld_addr     (ld_addr),
        .flush       (flush),
        .stall       (stall),
        .ld_done     (ld_done),
        .ld_data     (ld_data),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
`ifdef LOAD_MISALIGN_TRAP_EN
        .ld_misalign (ld_misalign),
`endif
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Present one load at a negedge, ack after v.waits REQ cycles, check the DONE cycle.
    // ld_valid is left asserted so a following call exercises back-to-back acceptance.
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        ld_valid  = 1'b1;
        ld_type   = v.ld_type;
        ld_addr   = v.addr;
        mem_ack   = 1'b0;
        #1;
        checkOutput("stall_accept", {31'b0, stall}, 32'd1);
        checkOutput("mem_req_accept", {31'b0, mem_req}, 32'd0);
        @(negedge clk);
        checkOutput("mem_addr", mem_addr, {v.addr[31:2], 2'b00});
        for (int w = 0; w < v.waits; w++) begin
            checkOutput("mem_req_wait", {31'b0, mem_req}, 32'd1);
            checkOutput("stall_wait", {31'b0, stall}, 32'd1);
            @(negedge clk);
        end
        checkOutput("mem_req_ack", {31'b0, mem_req}, 32'd1);
        checkOutput("stall_ack", {31'b0, stall}, 32'd1);
        mem_ack   = 1'b1;
        mem_rdata = v.rdata;
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = 32'hA5A5_A5A5;
        checkOutput("ld_done", {31'b0, ld_done}, 32'd1);
        checkOutput("ld_data", ld_data, v.exp_data);
        checkOutput("stall_done", {31'b0, stall}, 32'd0);
        checkOutput("mem_req_done", {31'b0, mem_req}, 32'd0);
        last_data = v.exp_data;
    endtask

    initial begin
        vecs[0] = '{LoadByte,  32'h0000_1003, 32'h80FF_1234, 0, 32'hFFFF_FF80};
        vecs[1] = '{LoadHalfU, 32'h0000_2002, 32'h9ABC_5678, 3, 32'h0000_9ABC};
        vecs[2] = '{LoadWord,  32'h0000_3000, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF};
        vecs[3] = '{LoadWord,  32'h0000_3004, 32'h0123_4567, 1, 32'h0123_4567};
        vecs[4] = '{LoadHalf,  32'h0000_4000, 32'h1234_F00D, 0, 32'hFFFF_F00D};
        vecs[5] = '{LoadHalf,  32'h0000_4002, 32'h7FFE_8001, 2, 32'h0000_7FFE};
        vecs[6] = '{LoadByteU, 32'h0000_5001, 32'h1122_8344, 0, 32'h0000_0083};
        vecs[7] = '{LoadByte,  32'h0000_5000, 32'h1122_8344, 0, 32'h0000_0044};
        vecs[8] = '{LoadByte,  32'h0000_5002, 32'h11A2_8344, 1, 32'hFFFF_FFA2};
        vecs[9] = '{LoadByteU, 32'h0000_5003, 32'hFE00_0000, 0, 32'h0000_00FE};
        num_vecs = 10;
`ifndef LOAD_MISALIGN_TRAP_EN
        vecs[10] = '{LoadWord,  32'h0000_6003, 32'hCAFE_F00D, 0, 32'hCAFE_F00D};
        vecs[11] = '{LoadHalfU, 32'h0000_6001, 32'hBEEF_1234, 1, 32'h0000_1234};
        num_vecs = 12;
`endif

        rst       = 1'b1;
        ld_valid  = 1'b0;
        ld_type   = 3'b000;
        ld_addr   = '0;
        flush     = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        last_data = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_stall", {31'b0, stall}, 32'd0);
        checkOutput("reset_ld_done", {31'b0, ld_done}, 32'd0);
        checkOutput("reset_ld_data", ld_data, 32'd0);
        checkOutput("reset_mem_req", {31'b0, mem_req}, 32'd0);
        checkOutput("reset_mem_addr", mem_addr, 32'd0);
`ifdef LOAD_MISALIGN_TRAP_EN
        checkOutput("reset_ld_misalign", {31'b0, ld_misalign}, 32'd0);
`endif
        rst = 1'b0;

        for (int i = 0; i < num_vecs; i++) begin
            applyStimulus(vecs[i]);
        end
        @(negedge clk);
        ld_valid = 1'b0;
        checkOutput("idle_after_done", {31'b0, ld_done}, 32'd0);

        // Illegal type must be ignored entirely.
        ld_valid = 1'b1;
        ld_type  = 3'b101;
        ld_addr  = 32'h0000_7000;
        #1;
        checkOutput("illegal_stall", {31'b0, stall}, 32'd0);
        @(negedge clk);
        checkOutput("illegal_mem_req", {31'b0, mem_req}, 32'd0);
        checkOutput("illegal_ld_done", {31'b0, ld_done}, 32'd0);

        // Flush in the accept cycle blocks acceptance.
        ld_type = LoadWord;
        flush   = 1'b1;
        #1;
        checkOutput("flush_accept_stall", {31'b0, stall}, 32'd0);
        @(negedge clk);
        flush = 1'b0;
        checkOutput("flush_accept_mem_req", {31'b0, mem_req}, 32'd0);
        ld_valid = 1'b0;

        // Flush in REQ without ack: DRAIN holds mem_req until ack, no ld_done.
        @(negedge clk);
        ld_valid = 1'b1;
        ld_type  = LoadWord;
        ld_addr  = 32'h0000_7008;
        @(negedge clk);
        checkOutput("drain_req", {31'b0, mem_req}, 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush    = 1'b0;
        ld_valid = 1'b0;
        checkOutput("drain_mem_req", {31'b0, mem_req}, 32'd1);
        checkOutput("drain_stall", {31'b0, stall}, 32'd1);
        checkOutput("drain_mem_addr", mem_addr, 32'h0000_7008);
        @(negedge clk);
        checkOutput("drain_mem_req_hold", {31'b0, mem_req}, 32'd1);
        mem_ack   = 1'b1;
        mem_rdata = 32'h1357_9BDF;
        @(negedge clk);
        mem_ack = 1'b0;
        checkOutput("drain_end_mem_req", {31'b0, mem_req}, 32'd0);
        checkOutput("drain_end_ld_done", {31'b0, ld_done}, 32'd0);
        checkOutput("drain_end_stall", {31'b0, stall}, 32'd0);
        checkOutput("drain_ld_data_kept", ld_data, last_data);
        @(negedge clk);
        checkOutput("drain_no_late_done", {31'b0, ld_done}, 32'd0);

        // Flush together with ack in REQ: data discarded, straight to IDLE.
        ld_valid = 1'b1;
        ld_type  = LoadByte;
        ld_addr  = 32'h0000_7010;
        @(negedge clk);
        flush     = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 32'h2468_ACE0;
        @(negedge clk);
        flush    = 1'b0;
        mem_ack  = 1'b0;
        ld_valid = 1'b0;
        checkOutput("flushack_ld_done", {31'b0, ld_done}, 32'd0);
        checkOutput("flushack_mem_req", {31'b0, mem_req}, 32'd0);
        checkOutput("flushack_ld_data", ld_data, last_data);

        // Reset while in REQ abandons the request.
        @(negedge clk);
        ld_valid = 1'b1;
        ld_type  = LoadWord;
        ld_addr  = 32'h0000_7020;
        @(negedge clk);
        checkOutput("rst_mid_req_before", {31'b0, mem_req}, 32'd1);
        rst      = 1'b1;
        ld_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_mid_mem_req", {31'b0, mem_req}, 32'd0);
        checkOutput("rst_mid_stall", {31'b0, stall}, 32'd0);
        checkOutput("rst_mid_ld_data", ld_data, 32'd0);
        checkOutput("rst_mid_ld_done", {31'b0, ld_done}, 32'd0);

`ifdef LOAD_MISALIGN_TRAP_EN
        // Misaligned halfword traps without touching the bus.
        @(negedge clk);
        ld_valid = 1'b1;
        ld_type  = LoadHalf;
        ld_addr  = 32'h0000_8001;
        #1;
        checkOutput("mis_stall_accept", {31'b0, stall}, 32'd1);
        checkOutput("mis_mem_req_accept", {31'b0, mem_req}, 32'd0);
        @(negedge clk);
        checkOutput("mis_pulse", {31'b0, ld_misalign}, 32'd1);
        checkOutput("mis_mem_req", {31'b0, mem_req}, 32'd0);
        checkOutput("mis_ld_done", {31'b0, ld_done}, 32'd0);
        checkOutput("mis_stall_after", {31'b0, stall}, 32'd0);
        checkOutput("mis_ld_data", ld_data, 32'd0);
        ld_valid = 1'b0;
        @(negedge clk);
        checkOutput("mis_pulse_end", {31'b0, ld_misalign}, 32'd0);
        checkOutput("mis_mem_req_end", {31'b0, mem_req}, 32'd0);
`endif

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
